data_mem_unit: RTL and testbench
================================

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter WIDTH, default 32; data/address width, only 32 supported.
REQ-002 Parameter TIMEOUT, default 16; maximum ACCESS cycles to wait for bus_ack, legal 2..255.
REQ-003 One clock; reset is asynchronous and active-high. Ports: clk in 1 (all logic on rising edge); rst in 1 (active-high async reset).
REQ-004 req_valid in 1 (access request); req_ready out 1 (unit can accept).
REQ-005 read_en in 1 (load); write_en in 1 (store); Funct3 in 3 (size/sign code).
REQ-006 Mem_addr_out in WIDTH (byte address from ALU); RS2_data_out in WIDTH (store data).
REQ-007 bus_req out 1; bus_we out 1; bus_addr out WIDTH (word-aligned, [1:0]=0); bus_wdata out WIDTH; bus_wstrb out 4.
REQ-008 bus_ack in 1 (access complete this cycle); bus_rdata in WIDTH (valid when bus_ack=1 and bus_we=0).
REQ-009 dmu_out_data out WIDTH (extended load result); done out 1 (completion pulse); err out 1 (error pulse, only with done).

Function
REQ-010 States: IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-011 Accept when req_valid=1 and req_ready=1; latch address, data, Funct3, op on that edge.
REQ-012 Legal loads: Funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
REQ-013 Error on accept (no bus access, go to RESP with err): read_en=write_en (both or neither), illegal Funct3, halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-014 Legal accept -> ACCESS; bus_req=1 from next cycle, held with stable bus_addr/bus_we/bus_wdata/bus_wstrb until bus_ack sampled high or timeout.
REQ-015 bus_addr = {addr[31:2],2'b00}; bus_we=1 for store.
REQ-016 Store: SB wstrb=1<<addr[1:0], byte replicated x4 in wdata; SH wstrb=0011 (addr[1]=0) or 1100, halfword replicated x2; SW wstrb=1111, wdata=RS2_data_out. Loads: wstrb=0000.
REQ-017 Load: select byte/halfword of bus_rdata by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; register into dmu_out_data on the ack edge.
REQ-018 bus_ack high in ACCESS -> bus_req low next cycle, state RESP.
REQ-019 RESP lasts one cycle: done=1, err per outcome; then IDLE. Next request acceptable the cycle after RESP.
REQ-020 Min latency: accept at edge N, bus_req high N+1, ack at N+1 -> done high in cycle N+2.
REQ-021 Wait counter clears on entering ACCESS, increments each ACCESS cycle without ack; at TIMEOUT cycles without ack, bus_req drops, RESP with err=1.
REQ-022 bus_ack in the same cycle the counter expires: ack wins, no error.
REQ-023 dmu_out_data changes only on successful load completion; stores, errors, timeouts leave it unchanged.
REQ-024 bus_ack while not in ACCESS ignored.
REQ-025 req_valid while req_ready=0 ignored (not queued).

Reset
REQ-026 rst=1 forces immediately: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, dmu_out_data=0, done=0, err=0, counter=0; req_ready=1 after release.
REQ-027 Reset mid-ACCESS or mid-RESP abandons the access; no done pulse follows.

Verification
REQ-028 LB addr 0x103, bus_rdata 0x80FF_0000, ack first cycle -> bus_addr 0x100, dmu_out_data 0xFFFF_FF80, done at N+2, err=0.
REQ-029 SH addr 0x202, RS2=0x1234_ABCD -> bus_wstrb 1100, bus_wdata 0xABCD_ABCD, bus_we=1, done err=0, dmu_out_data unchanged.
REQ-030 LW addr 0x101 -> no bus_req, done=1 err=1 at N+1; LHU addr 0x106 rdata 0x9876_0000 -> 0x0000_9876.
REQ-031 LW with ack withheld, TIMEOUT=16 -> bus_req high exactly 16 cycles, then done+err; repeat with ack on 16th cycle -> done, err=0, data loaded.
REQ-032 read_en=write_en=1 -> err; rst asserted during ACCESS -> bus_req low same cycle, no done, req_ready=1 after release.

Source files
------------

// File: rtl/data_mem_unit_if.sv
// Request/bus/response bundle between a load-store requester, the data memory
// unit and the data bus. The master side plays both requester and bus slave.
interface data_mem_unit_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             read_en;
  logic             write_en;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] Mem_addr_out;
  logic [WIDTH-1:0] RS2_data_out;
  logic             bus_req;
  logic             bus_we;
  logic [WIDTH-1:0] bus_addr;
  logic [WIDTH-1:0] bus_wdata;
  logic [3:0]       bus_wstrb;
  logic             bus_ack;
  logic [WIDTH-1:0] bus_rdata;
  logic [WIDTH-1:0] dmu_out_data;
  logic             done;
  logic             err;

  modport slave (
    input  req_valid, read_en, write_en, Funct3, Mem_addr_out, RS2_data_out,
           bus_ack, bus_rdata,
    output req_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
           dmu_out_data, done, err
  );

  modport master (
    output req_valid, read_en, write_en, Funct3, Mem_addr_out, RS2_data_out,
           bus_ack, bus_rdata,
    input  req_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
           dmu_out_data, done, err
  );
endinterface

// File: rtl/data_mem_unit.sv
// Data memory unit: turns one load/store request into a single word-aligned bus
// access with byte strobes, load extension, alignment checks and ack timeout.
module data_mem_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  data_mem_unit_if.slave dmu
);
  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | bus_req held, waiting for bus_ack or timeout
  // RESP   | one-cycle done pulse, err reports outcome
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       err_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  logic             req_err, op_bad, f3_bad, align_bad;
  logic             timed_out;
  logic [3:0]       wstrb_n;
  logic [WIDTH-1:0] wdata_n;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_val;

  always_comb begin
    op_bad    = (dmu.read_en == dmu.write_en);
    f3_bad    = dmu.write_en ? (dmu.Funct3[2] || dmu.Funct3[1:0] == 2'b11)
                             : (dmu.Funct3 == 3'b011 || dmu.Funct3[2:1] == 2'b11);
    align_bad = (dmu.Funct3[1:0] == 2'b01 && dmu.Mem_addr_out[0]) ||
                (dmu.Funct3[1:0] == 2'b10 && dmu.Mem_addr_out[1:0] != 2'b00);
    req_err   = op_bad || f3_bad || align_bad;
  end

  // Store lanes: narrow data is replicated so the strobes alone pick the lane.
  always_comb begin
    wstrb_n = 4'b0000;
    wdata_n = '0;
    if (dmu.write_en) begin
      case (dmu.Funct3[1:0])
        2'b00: begin
          wstrb_n = 4'b0001 << dmu.Mem_addr_out[1:0];
          wdata_n = {4{dmu.RS2_data_out[7:0]}};
        end
        2'b01: begin
          wstrb_n = dmu.Mem_addr_out[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{dmu.RS2_data_out[15:0]}};
        end
        default: begin
          wstrb_n = 4'b1111;
          wdata_n = dmu.RS2_data_out;
        end
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'b00:   byte_sel = dmu.bus_rdata[7:0];
      2'b01:   byte_sel = dmu.bus_rdata[15:8];
      2'b10:   byte_sel = dmu.bus_rdata[23:16];
      default: byte_sel = dmu.bus_rdata[31:24];
    endcase
    half_sel = off_q[1] ? dmu.bus_rdata[31:16] : dmu.bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = dmu.bus_rdata;
    endcase
  end

  assign timed_out = (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dmu.req_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  if (dmu.bus_ack || timed_out) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt         <= '0;
      err_q            <= 1'b0;
      f3_q             <= '0;
      off_q            <= '0;
      dmu.bus_we       <= 1'b0;
      dmu.bus_addr     <= '0;
      dmu.bus_wdata    <= '0;
      dmu.bus_wstrb    <= '0;
      dmu.dmu_out_data <= '0;
    end else begin
      case (state)
        IDLE: if (dmu.req_valid) begin
          err_q <= req_err;
          if (!req_err) begin
            wait_cnt      <= '0;
            f3_q          <= dmu.Funct3;
            off_q         <= dmu.Mem_addr_out[1:0];
            dmu.bus_we    <= dmu.write_en;
            dmu.bus_addr  <= {dmu.Mem_addr_out[WIDTH-1:2], 2'b00};
            dmu.bus_wdata <= wdata_n;
            dmu.bus_wstrb <= wstrb_n;
          end
        end
        ACCESS: begin
          // An ack in the expiring cycle still counts as success.
          if (dmu.bus_ack) begin
            err_q <= 1'b0;
            if (!dmu.bus_we) dmu.dmu_out_data <= load_val;
          end else if (timed_out) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmu.req_ready = (state == IDLE);
  assign dmu.bus_req   = (state == ACCESS);
  assign dmu.done      = (state == RESP);
  assign dmu.err       = (state == RESP) && err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed table-driven bench for data_mem_unit plus hand sequences for
// timeout, ack-on-last-cycle, ignored inputs and reset during an access.
module tb_data_mem_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  data_mem_unit_if #(.WIDTH(32)) dmu ();
  data_mem_unit #(.WIDTH(32), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .dmu(dmu));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    int          ack_delay;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2);
    dmu.req_valid = 1'b1; dmu.read_en = rd; dmu.write_en = wr;
    dmu.Funct3 = f3; dmu.Mem_addr_out = addr; dmu.RS2_data_out = rs2;
    tick();
    dmu.req_valid = 1'b0; dmu.read_en = 1'b0; dmu.write_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    check({v.name, " ready"}, 32'(dmu.req_ready), 32'd1);
    drive_req(v.rd, v.wr, v.f3, v.addr, v.rs2);
    if (v.exp_err) begin
      check({v.name, " bus_req"}, 32'(dmu.bus_req), 32'd0);
      check({v.name, " done"}, 32'(dmu.done), 32'd1);
      check({v.name, " err"}, 32'(dmu.err), 32'd1);
      check({v.name, " data"}, dmu.dmu_out_data, v.exp_data);
      tick();
      check({v.name, " done_low"}, 32'(dmu.done), 32'd0);
    end else begin
      check({v.name, " bus_req"}, 32'(dmu.bus_req), 32'd1);
      check({v.name, " bus_addr"}, dmu.bus_addr, v.exp_addr);
      check({v.name, " bus_we"}, 32'(dmu.bus_we), 32'(v.wr));
      check({v.name, " wstrb"}, 32'(dmu.bus_wstrb), 32'(v.exp_wstrb));
      if (v.wr) check({v.name, " wdata"}, dmu.bus_wdata, v.exp_wdata);
      for (int i = 0; i < v.ack_delay; i++) begin
        tick();
        check({v.name, " bus_req_hold"}, 32'(dmu.bus_req), 32'd1);
      end
      dmu.bus_ack = 1'b1; dmu.bus_rdata = v.rdata;
      tick();
      dmu.bus_ack = 1'b0; dmu.bus_rdata = 32'h0;
      check({v.name, " bus_req_drop"}, 32'(dmu.bus_req), 32'd0);
      check({v.name, " done"}, 32'(dmu.done), 32'd1);
      check({v.name, " err"}, 32'(dmu.err), 32'd0);
      check({v.name, " data"}, dmu.dmu_out_data, v.exp_data);
      tick();
      check({v.name, " done_low"}, 32'(dmu.done), 32'd0);
    end
  endtask

  task automatic add(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                     input int dly, input logic e, input logic [31:0] ea, input logic [3:0] es,
                     input logic [31:0] ew, input logic [31:0] ed);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2;
    v.rdata = rdata; v.ack_delay = dly; v.exp_err = e; v.exp_addr = ea;
    v.exp_wstrb = es; v.exp_wdata = ew; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    logic saw_done;
    dmu.req_valid = 0; dmu.read_en = 0; dmu.write_en = 0; dmu.Funct3 = 0;
    dmu.Mem_addr_out = 0; dmu.RS2_data_out = 0; dmu.bus_ack = 0; dmu.bus_rdata = 0;

    // expected dmu_out_data accumulates through the table in order
    add("lb_103",   1,0,3'b000,32'h103,32'h0,       32'h80FF_0000,0,0,32'h100,4'b0000,32'h0,        32'hFFFF_FF80);
    add("sh_202",   0,1,3'b001,32'h202,32'h1234_ABCD,32'h0,       0,0,32'h200,4'b1100,32'hABCD_ABCD,32'hFFFF_FF80);
    add("lw_mis",   1,0,3'b010,32'h101,32'h0,       32'h0,        0,1,32'h0,  4'b0000,32'h0,        32'hFFFF_FF80);
    add("lhu_106",  1,0,3'b101,32'h106,32'h0,       32'h9876_0000,0,0,32'h104,4'b0000,32'h0,        32'h0000_9876);
    add("sb_301",   0,1,3'b000,32'h301,32'h0000_00A5,32'h0,       2,0,32'h300,4'b0010,32'hA5A5_A5A5,32'h0000_9876);
    add("lh_400",   1,0,3'b001,32'h400,32'h0,       32'h1234_8001,1,0,32'h400,4'b0000,32'h0,        32'hFFFF_8001);
    add("lbu_502",  1,0,3'b100,32'h502,32'h0,       32'h00C3_0000,0,0,32'h500,4'b0000,32'h0,        32'h0000_00C3);
    add("sw_604",   0,1,3'b010,32'h604,32'hDEAD_BEEF,32'h0,       0,0,32'h604,4'b1111,32'hDEAD_BEEF,32'h0000_00C3);
    add("both_op",  1,1,3'b010,32'h700,32'h0,       32'h0,        0,1,32'h0,  4'b0000,32'h0,        32'h0000_00C3);
    add("lh_mis",   1,0,3'b001,32'h201,32'h0,       32'h0,        0,1,32'h0,  4'b0000,32'h0,        32'h0000_00C3);
    add("ld_f3_011",1,0,3'b011,32'h200,32'h0,       32'h0,        0,1,32'h0,  4'b0000,32'h0,        32'h0000_00C3);
    add("st_f3_100",0,1,3'b100,32'h200,32'h0,       32'h0,        0,1,32'h0,  4'b0000,32'h0,        32'h0000_00C3);
    add("no_op",    0,0,3'b010,32'h200,32'h0,       32'h0,        0,1,32'h0,  4'b0000,32'h0,        32'h0000_00C3);
    add("lw_700",   1,0,3'b010,32'h700,32'h0,       32'hCAFE_F00D,3,0,32'h700,4'b0000,32'h0,        32'hCAFE_F00D);
    add("lb_pos",   1,0,3'b000,32'h010,32'h0,       32'h0000_007F,0,0,32'h010,4'b0000,32'h0,        32'h0000_007F);

    repeat (2) @(posedge clk);
    #1;
    check("rst bus_req", 32'(dmu.bus_req), 32'd0);
    check("rst done", 32'(dmu.done), 32'd0);
    rst = 1'b0;
    tick();
    check("rst ready", 32'(dmu.req_ready), 32'd1);
    check("rst bus_addr", dmu.bus_addr, 32'h0);
    check("rst wstrb", 32'(dmu.bus_wstrb), 32'h0);
    check("rst data", dmu.dmu_out_data, 32'h0);
    check("rst err", 32'(dmu.err), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // ack withheld: bus_req for exactly 16 cycles then done+err
    drive_req(1, 0, 3'b010, 32'h800, 32'h0);
    n = 0;
    while (dmu.bus_req && n < 40) begin n++; tick(); end
    check("to cycles", 32'(n), 32'd16);
    check("to done", 32'(dmu.done), 32'd1);
    check("to err", 32'(dmu.err), 32'd1);
    check("to data", dmu.dmu_out_data, 32'h0000_007F);
    tick();

    // ack on the 16th cycle wins
    drive_req(1, 0, 3'b010, 32'h804, 32'h0);
    n = 0;
    while (dmu.bus_req && n < 40) begin
      n++;
      if (n == 16) begin dmu.bus_ack = 1'b1; dmu.bus_rdata = 32'h5566_7788; end
      tick();
      dmu.bus_ack = 1'b0;
    end
    check("ack16 cycles", 32'(n), 32'd16);
    check("ack16 done", 32'(dmu.done), 32'd1);
    check("ack16 err", 32'(dmu.err), 32'd0);
    check("ack16 data", dmu.dmu_out_data, 32'h5566_7788);
    tick();

    // stray ack in IDLE is ignored
    dmu.bus_ack = 1'b1; dmu.bus_rdata = 32'h1111_1111;
    tick(); tick();
    dmu.bus_ack = 1'b0;
    check("idle_ack done", 32'(dmu.done), 32'd0);
    check("idle_ack data", dmu.dmu_out_data, 32'h5566_7788);

    // request presented while busy is not queued
    drive_req(1, 0, 3'b010, 32'h900, 32'h0);
    dmu.req_valid = 1'b1; dmu.write_en = 1'b1; dmu.Funct3 = 3'b010; dmu.Mem_addr_out = 32'hA00;
    tick();
    dmu.req_valid = 1'b0; dmu.write_en = 1'b0;
    check("busy addr", dmu.bus_addr, 32'h900);
    dmu.bus_ack = 1'b1; dmu.bus_rdata = 32'h0BAD_F00D;
    tick();
    dmu.bus_ack = 1'b0;
    check("busy done", 32'(dmu.done), 32'd1);
    tick();
    check("busy idle", 32'(dmu.bus_req), 32'd0);
    tick();
    check("busy no_queue", 32'(dmu.bus_req), 32'd0);

    // reset in the middle of an access
    drive_req(0, 1, 3'b010, 32'hB00, 32'h1234_5678);
    check("mid bus_req", 32'(dmu.bus_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid rst bus_req", 32'(dmu.bus_req), 32'd0);
    check("mid rst addr", dmu.bus_addr, 32'h0);
    check("mid rst data", dmu.dmu_out_data, 32'h0);
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dmu.done) saw_done = 1'b1;
    end
    check("mid no_done", 32'(saw_done), 32'd0);
    check("mid ready", 32'(dmu.req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
